// File: rtl/neuron_sweep_ctrl.sv
// Event-driven sweep sequencer for the IF-neuron datapath: one SRAM read/modify/write
// pass over all post-synaptic neurons per input event, time step, or sample end.
module neuron_sweep_ctrl #(
  parameter int N_POST       = 256,
  parameter int TIME_STEP    = 8,
  parameter int AER_IN_WIDTH = 12
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic                    aer_valid,
  input  logic [AER_IN_WIDTH-1:0] aer_addr,
  output logic                    aer_ready,
  input  logic                    step_end,
  output logic                    sram_re,
  output logic [$clog2(N_POST)-1:0] sram_raddr,
  output logic [AER_IN_WIDTH-1:0] pre_addr,
  output logic                    sram_we,
  output logic [$clog2(N_POST)-1:0] sram_waddr,
  output logic                    neuron_event,
  output logic                    time_step_event,
  output logic                    time_ref_event,
  output logic [((TIME_STEP > 1) ? $clog2(TIME_STEP) : 1)-1:0] current_time_step,
  input  logic                    spike_in,
  output logic                    spike_valid,
  output logic [$clog2(N_POST)-1:0] spike_addr,
  output logic                    busy,
  output logic                    done
);

  localparam int AW  = $clog2(N_POST);
  localparam int TSW = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;
  localparam int CW  = $clog2(N_POST + 1);
  localparam logic [CW-1:0]  LAST    = CW'(N_POST);
  localparam logic [TSW-1:0] TS_LAST = TSW'(TIME_STEP - 1);

  typedef enum logic [2:0] {IDLE, WAIT_EV, ACC, STEP, REF, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          step_end_pend;

  // cnt is the index of the sweep cycle currently presented on the outputs:
  // cycle k reads neuron k (k < N_POST) and writes back neuron k-1 (k >= 1).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= IDLE;
      cnt               <= '0;
      step_end_pend     <= 1'b0;
      aer_ready         <= 1'b0;
      sram_re           <= 1'b0;
      sram_raddr        <= '0;
      pre_addr          <= '0;
      sram_we           <= 1'b0;
      sram_waddr        <= '0;
      neuron_event      <= 1'b0;
      time_step_event   <= 1'b0;
      time_ref_event    <= 1'b0;
      current_time_step <= '0;
      spike_valid       <= 1'b0;
      spike_addr        <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      done        <= 1'b0;
      spike_valid <= (state == STEP) && sram_we && spike_in;
      if ((state == STEP) && sram_we && spike_in)
        spike_addr <= sram_waddr;

      if (step_end && (state != IDLE) && ((state != WAIT_EV) || aer_valid))
        step_end_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= WAIT_EV;
            aer_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end

        WAIT_EV: begin
          if (aer_valid) begin
            pre_addr  <= aer_addr;
            state     <= ACC;
            aer_ready <= 1'b0;
            cnt <= '0; sram_re <= 1'b1; sram_raddr <= '0;
          end else if (step_end || step_end_pend) begin
            state         <= STEP;
            step_end_pend <= 1'b0;
            aer_ready     <= 1'b0;
            cnt <= '0; sram_re <= 1'b1; sram_raddr <= '0;
          end
        end

        ACC, STEP, REF: begin
          if (cnt == LAST) begin
            sram_re         <= 1'b0;
            sram_we         <= 1'b0;
            neuron_event    <= 1'b0;
            time_step_event <= 1'b0;
            time_ref_event  <= 1'b0;
            if (state == ACC) begin
              if (step_end_pend) begin
                state         <= STEP;
                step_end_pend <= 1'b0;
                cnt <= '0; sram_re <= 1'b1; sram_raddr <= '0;
              end else begin
                state     <= WAIT_EV;
                aer_ready <= 1'b1;
              end
            end else if (state == STEP) begin
              current_time_step <= (current_time_step == TS_LAST) ? '0 : current_time_step + TSW'(1);
              if (current_time_step == TS_LAST) begin
                state <= REF;
                cnt <= '0; sram_re <= 1'b1; sram_raddr <= '0;
              end else begin
                state     <= WAIT_EV;
                aer_ready <= 1'b1;
              end
            end else begin
              current_time_step <= '0;
              state             <= DONE;
              done              <= 1'b1;
            end
          end else begin
            cnt             <= cnt + CW'(1);
            sram_re         <= (cnt != LAST - CW'(1));
            sram_raddr      <= AW'(cnt + CW'(1));
            sram_we         <= 1'b1;
            sram_waddr      <= AW'(cnt);
            neuron_event    <= (state == ACC);
            time_step_event <= (state == STEP);
            time_ref_event  <= (state == REF);
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
